// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns, special codes, capture FSM states.
// Used by both the display encoder and the capture monitor so the two never disagree.
package seg7_pkg;

    typedef logic [6:0] seg_t;  // bit6=g ... bit0=a, active-low

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Display-side bus seen by the capture block: segment/strobe pins in, decoded digits out.
// SEG7_CAP_DP_EN adds the decimal-point pin and its captured per-digit output.
interface seg7_capture_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();
    seg_t                      seg_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic [4*NUM_DIGITS-1:0]   digit;
    logic [NUM_DIGITS-1:0]     digit_valid;
    logic [NUM_DIGITS-1:0]     digit_err;
    logic                      update;
`ifdef SEG7_CAP_DP_EN
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     digit_dp;
`endif

    modport master (
        output seg_n, output an_n,
`ifdef SEG7_CAP_DP_EN
        output dp_n, input digit_dp,
`endif
        input digit, input digit_valid, input digit_err, input update
    );

    modport slave (
        input seg_n, input an_n,
`ifdef SEG7_CAP_DP_EN
        input dp_n, output digit_dp,
`endif
        output digit, output digit_valid, output digit_err, output update
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern -> BCD lookup.
// Blank maps to CODE_BLANK without error; any unlisted pattern maps to CODE_ERR with err set.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t       pat,
    output logic [3:0] code,
    output logic       err
);
    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        case (pat)
            SEG_0:     begin code = 4'd0;       err = 1'b0; end
            SEG_1:     begin code = 4'd1;       err = 1'b0; end
            SEG_2:     begin code = 4'd2;       err = 1'b0; end
            SEG_3:     begin code = 4'd3;       err = 1'b0; end
            SEG_4:     begin code = 4'd4;       err = 1'b0; end
            SEG_5:     begin code = 4'd5;       err = 1'b0; end
            SEG_6:     begin code = 4'd6;       err = 1'b0; end
            SEG_7:     begin code = 4'd7;       err = 1'b0; end
            SEG_8:     begin code = 4'd8;       err = 1'b0; end
            SEG_9:     begin code = 4'd9;       err = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
            default:   ;
        endcase
    end
endmodule

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment monitor: synchronizes pins, waits for a stable strobe/pattern dwell,
// writes one decoded value per dwell and ages digits out. SEG7_CAP_DP_EN also captures the DP.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    seg7_capture_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef SEG7_CAP_DP_EN
    localparam int PW = 8;
`else
    localparam int PW = 7;
`endif

    logic [PW-1:0]         raw, pat_s1, pat_s2, pat;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;

`ifdef SEG7_CAP_DP_EN
    assign raw = {bus.dp_n, bus.seg_n};
`else
    assign raw = bus.seg_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_s1 <= '0;
            pat_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            pat_s1 <= raw;
            pat_s2 <= pat_s1;
            an_s1  <= bus.an_n;
            an_s2  <= an_s1;
        end
    end

    // A sample counts only when exactly one strobe is active.
    logic [3:0]    nlow;
    logic [IW-1:0] sidx, idx;
    logic          q, same, wr_en;

    always_comb begin
        nlow = '0;
        sidx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2[i]) begin
                nlow = nlow + 4'd1;
                sidx = IW'(i);
            end
        end
    end

    assign q = (nlow == 4'd1);

    cap_state_t state;
    logic [7:0] cnt;
    logic       update_q;

    assign same  = (sidx == idx) && (pat_s2 == pat);
    assign wr_en = (state == ST_TRACK) && q && same && (cnt == 8'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            pat      <= '0;
            cnt      <= '0;
            update_q <= 1'b0;
        end else begin
            update_q <= wr_en;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (!q) begin
                        state <= ST_IDLE;
                    end else if (state == ST_IDLE || !same) begin
                        state <= ST_TRACK;
                        idx   <= sidx;
                        pat   <= pat_s2;
                        cnt   <= 8'd1;
                    end
                end
                ST_TRACK: begin
                    if (!q) begin
                        state <= ST_IDLE;
                    end else if (!same) begin
                        idx <= sidx;
                        pat <= pat_s2;
                        cnt <= 8'd1;
                    end else if (cnt == 8'(STABLE_CYCLES - 1)) begin
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [3:0] dec_code;
    logic       dec_err;

    seg7_pattern_decode u_dec (
        .pat  (pat[6:0]),
        .code (dec_code),
        .err  (dec_err)
    );

    logic [NUM_DIGITS-1:0][3:0] digit_r;
    logic [NUM_DIGITS-1:0]      valid_r, err_r;
`ifdef SEG7_CAP_DP_EN
    logic [NUM_DIGITS-1:0]      dp_r;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [3:0]    d_q;
        logic          e_q, v_q;
        logic [TW-1:0] t_q;
        logic          hit;

        assign hit = wr_en && (idx == IW'(g));

        // A write on the expiry cycle takes priority and restarts the age count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q <= '0;
                e_q <= 1'b0;
                v_q <= 1'b0;
                t_q <= '0;
            end else if (hit) begin
                d_q <= dec_code;
                e_q <= dec_err;
                v_q <= 1'b1;
                t_q <= '0;
            end else if (v_q) begin
                if (t_q == TW'(TIMEOUT_CYCLES - 1))
                    v_q <= 1'b0;
                else
                    t_q <= t_q + TW'(1);
            end
        end

`ifdef SEG7_CAP_DP_EN
        logic p_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      p_q <= 1'b0;
            else if (hit) p_q <= ~pat[7];
        end
        assign dp_r[g] = p_q;
`endif

        assign digit_r[g] = d_q;
        assign valid_r[g] = v_q;
        assign err_r[g]   = e_q;
    end

    assign bus.digit       = digit_r;
    assign bus.digit_valid = valid_r;
    assign bus.digit_err   = err_r;
    assign bus.update      = update_q;
`ifdef SEG7_CAP_DP_EN
    assign bus.digit_dp    = dp_r;
`endif

endmodule
